// File: rtl/huffman_merge_split.sv
// Huffman tree builder for six symbols: merges the two lightest groups over five rounds,
// then replays the recorded splits root-first as data_l/data_s masks for the encoder cells.
module huffman_merge_split #(
  parameter int unsigned CW = 8,
  parameter int unsigned WW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] cnt1,
  input  logic [CW-1:0] cnt2,
  input  logic [CW-1:0] cnt3,
  input  logic [CW-1:0] cnt4,
  input  logic [CW-1:0] cnt5,
  input  logic [CW-1:0] cnt6,
  output logic [2:0]    state,
  output logic [5:0]    data_l,
  output logic [5:0]    data_s,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StCodev      = 3'd1,
    StMerge      = 3'd3,
    StDecode     = 3'd4,
    StSortDecode = 3'd5,
    StDone       = 3'd6
  } state_e;

  state_e          state_q;
  logic [WW-1:0]   weight_q [6];
  logic [5:0]      mask_q   [6];
  logic [5:0]      active_q;
  logic [5:0]      stack_s_q [5];
  logic [5:0]      stack_l_q [5];
  logic [2:0]      rnd_q;

  logic [2:0] min1, min2, lo, hi;
  logic       found1, found2;

  assign state = state_q;

  // Two lightest active slots; strict < keeps the lowest index on ties.
  always_comb begin
    min1   = 3'd0;
    min2   = 3'd0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (active_q[i] && (!found1 || weight_q[i] < weight_q[min1])) begin
        min1   = 3'(i);
        found1 = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (active_q[i] && 3'(i) != min1 && (!found2 || weight_q[i] < weight_q[min2])) begin
        min2   = 3'(i);
        found2 = 1'b1;
      end
    end
    lo = (min1 < min2) ? min1 : min2;
    hi = (min1 < min2) ? min2 : min1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      data_l   <= '0;
      data_s   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      active_q <= '0;
      rnd_q    <= '0;
      for (int i = 0; i < 6; i++) begin
        weight_q[i] <= '0;
        mask_q[i]   <= '0;
      end
      for (int i = 0; i < 5; i++) begin
        stack_s_q[i] <= '0;
        stack_l_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StCodev;
            busy        <= 1'b1;
            rnd_q       <= '0;
            active_q    <= 6'b111111;
            weight_q[0] <= {{(WW-CW){1'b0}}, cnt1};
            weight_q[1] <= {{(WW-CW){1'b0}}, cnt2};
            weight_q[2] <= {{(WW-CW){1'b0}}, cnt3};
            weight_q[3] <= {{(WW-CW){1'b0}}, cnt4};
            weight_q[4] <= {{(WW-CW){1'b0}}, cnt5};
            weight_q[5] <= {{(WW-CW){1'b0}}, cnt6};
            for (int i = 0; i < 6; i++) begin
              mask_q[i] <= 6'b100000 >> i;
            end
          end
        end
        StCodev: state_q <= StMerge;
        StMerge: begin
          stack_s_q[rnd_q] <= mask_q[min1];
          stack_l_q[rnd_q] <= mask_q[min2];
          weight_q[lo]     <= weight_q[min1] + weight_q[min2];
          mask_q[lo]       <= mask_q[min1] | mask_q[min2];
          active_q[hi]     <= 1'b0;
          if (rnd_q == 3'd4) begin
            // Root split goes straight to the outputs; its stack slot is still being written.
            state_q <= StDecode;
            rnd_q   <= '0;
            data_s  <= mask_q[min1];
            data_l  <= mask_q[min2];
          end else begin
            rnd_q <= rnd_q + 3'd1;
          end
        end
        StDecode: begin
          if (rnd_q == 3'd4) begin
            state_q <= StDone;
            data_s  <= '0;
            data_l  <= '0;
            done    <= 1'b1;
          end else begin
            data_s <= stack_s_q[3'd3 - rnd_q];
            data_l <= stack_l_q[3'd3 - rnd_q];
            rnd_q  <= rnd_q + 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          data_s  <= '0;
          data_l  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_merge_split.sv
// Scoreboard bench for huffman_merge_split: expected per-cycle outputs are queued at start
// and popped each falling edge.
module tb_huffman_merge_split;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] cnt [6];
  logic [2:0] state;
  logic [5:0] data_l, data_s;
  logic       busy, done;

  huffman_merge_split #(.CW(8), .WW(11)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cnt1   (cnt[0]),
    .cnt2   (cnt[1]),
    .cnt3   (cnt[2]),
    .cnt4   (cnt[3]),
    .cnt5   (cnt[4]),
    .cnt6   (cnt[5]),
    .state  (state),
    .data_l (data_l),
    .data_s (data_s),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] sb [$];
  logic [16:0] obs, exp_v;
  logic [5:0]  ms [5];
  logic [5:0]  ml [5];

  assign obs = {state, data_s, data_l, busy, done};

  function automatic logic [16:0] pk(input logic [2:0] st, input logic [5:0] s,
                                     input logic [5:0] l, input logic b, input logic d);
    return {st, s, l, b, d};
  endfunction

  // Reference tree build: stable sort of active groups by (weight, slot), take the first two.
  task automatic model(input int c [6]);
    int w [6];
    logic [5:0] m [6];
    bit a [6];
    int ord [$];
    int x, y, lo, hi, t, sum;
    for (int i = 0; i < 6; i++) begin
      w[i] = c[i];
      m[i] = 6'b100000 >> i;
      a[i] = 1'b1;
    end
    for (int r = 0; r < 5; r++) begin
      ord = {};
      for (int i = 0; i < 6; i++) if (a[i]) ord.push_back(i);
      for (int p = 0; p < ord.size(); p++) begin
        for (int q = 0; q < ord.size() - 1 - p; q++) begin
          if (w[ord[q]] > w[ord[q+1]] || (w[ord[q]] == w[ord[q+1]] && ord[q] > ord[q+1])) begin
            t = ord[q]; ord[q] = ord[q+1]; ord[q+1] = t;
          end
        end
      end
      x = ord[0];
      y = ord[1];
      ms[r] = m[x];
      ml[r] = m[y];
      lo  = (x < y) ? x : y;
      hi  = (x < y) ? y : x;
      sum = w[x] + w[y];
      m[lo] = m[x] | m[y];
      w[lo] = sum;
      a[hi] = 1'b0;
    end
  endtask

  task automatic push_seq();
    sb.push_back(pk(3'd1, 6'd0, 6'd0, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) sb.push_back(pk(3'd3, 6'd0, 6'd0, 1'b1, 1'b0));
    for (int j = 0; j < 5; j++) sb.push_back(pk(3'd4, ms[4-j], ml[4-j], 1'b1, 1'b0));
    sb.push_back(pk(3'd6, 6'd0, 6'd0, 1'b1, 1'b1));
    sb.push_back(pk(3'd0, 6'd0, 6'd0, 1'b0, 1'b0));
  endtask

  // Pulse start for one edge with the given counts; first observation follows on next negedge.
  task automatic launch(input int c [6]);
    @(negedge clk);
    for (int i = 0; i < 6; i++) cnt[i] = 8'(c[i]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) cnt[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 17'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc%0d got %h want %h", k, obs, 17'd0);
      end
    end
  endtask

  task automatic test_known();
    int c [6] = '{1, 2, 3, 4, 5, 6};
    ms = '{6'b100000, 6'b110000, 6'b000100, 6'b111000, 6'b000110};
    ml = '{6'b010000, 6'b001000, 6'b000010, 6'b000001, 6'b111001};
    push_seq();
    launch(c);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL known_123456 cyc%0d got %h want %h", k + 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_ties();
    int c [6] = '{5, 5, 5, 5, 5, 5};
    int j = 0;
    model(c);
    push_seq();
    launch(c);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL ties cyc%0d got %h want %h", k + 1, obs, exp_v);
      end
      if (state == 3'd4) begin
        n_cmp++;
        if ((data_s & data_l) !== 6'd0 || data_s == 6'd0 || data_l == 6'd0) begin
          n_bad++;
          $display("FAIL ties_disjoint j%0d got s=%b l=%b want disjoint nonzero", j, data_s, data_l);
        end
        if (j == 0) begin
          n_cmp++;
          if ((data_s | data_l) !== 6'b111111) begin
            n_bad++;
            $display("FAIL ties_root got %b want 111111", data_s | data_l);
          end
        end
        if (j == 4) begin
          n_cmp++;
          if ({data_s, data_l} !== {6'b100000, 6'b010000}) begin
            n_bad++;
            $display("FAIL ties_last got s=%b l=%b want s=100000 l=010000", data_s, data_l);
          end
        end
        j++;
      end
    end
  endtask

  task automatic test_model_run(input int c [6], input string name, input bit disturb);
    model(c);
    push_seq();
    launch(c);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL %s cyc%0d got %h want %h", name, k + 1, obs, exp_v);
      end
      if (disturb && k == 2) begin
        start = 1'b1;
        for (int i = 0; i < 6; i++) cnt[i] = 8'($urandom_range(0, 255));
      end
      if (disturb && k == 3) start = 1'b0;
      if (disturb && k == 7) for (int i = 0; i < 6; i++) cnt[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic test_reset_mid();
    int c [6] = '{9, 1, 4, 4, 0, 12};
    model(c);
    push_seq();
    launch(c);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL pre_reset cyc%0d got %h want %h", k + 1, obs, exp_v);
      end
    end
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (obs !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_mid got %h want %h", obs, 17'd0);
    end
    test_model_run(c, "after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    int c [6];
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 6; i++) c[i] = (n == 3 && i == 2) ? 0 : $urandom_range(0, 255);
      test_model_run(c, "random", 1'b0);
    end
  endtask

  initial begin
    int cmax [6] = '{255, 255, 255, 255, 255, 255};
    int cdis [6] = '{7, 3, 9, 1, 4, 2};
    test_reset();
    test_known();
    test_ties();
    test_model_run(cmax, "max255", 1'b0);
    test_model_run(cdis, "disturb", 1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
